// File: rtl/wb_grf_commit_pkg.sv
// Shared types and constants for the writeback / GRF commit slice.
// Provides register-name constants, T_new encodings, the commit trace record
// layout and the writeback data select helper.
package wb_grf_commit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

    // Cycles until the W-stage result exists; only "now" may be forwarded
    localparam logic [1:0] T_NEW_NOW = 2'b00;
    localparam logic [1:0] T_NEW_ONE = 2'b01;
    localparam logic [1:0] T_NEW_TWO = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } traceRec_t;

    localparam int unsigned TRACE_W = $bits(traceRec_t);

    // Writeback source select: link value beats load data beats ALU result
    function automatic logic [XLEN-1:0] selWbData(
        input logic            jalSel,
        input logic            memToReg,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] aluOut,
        input logic [XLEN-1:0] readData,
        input logic [XLEN-1:0] linkOffset
    );
        if (jalSel)   return pc + linkOffset;
        if (memToReg) return readData;
        return aluOut;
    endfunction

endpackage

// File: rtl/wb_grf_commit_if.sv
// W-stage bundle, D-stage read ports, forwarding and commit-trace bus.
// master: pipeline / harness side (drives W-stage, read addresses, trace_ready)
// slave : wb_grf_commit (returns read data, forwarding info, trace head)
interface wb_grf_commit_if;
    import wb_grf_commit_pkg::*;

    logic                RegWriteW;
    logic                MemtoRegW;
    logic                jal_selW;
    logic [XLEN-1:0]     ALUOutW;
    logic [XLEN-1:0]     ReadDataW;
    logic [REG_AW-1:0]   WriteRegW;
    logic [XLEN-1:0]     PcW;
    logic [XLEN-1:0]     InstrW;
    logic [1:0]          T_new_W;
    logic [REG_AW-1:0]   A1_D;
    logic [REG_AW-1:0]   A2_D;
    logic [XLEN-1:0]     RD1_D;
    logic [XLEN-1:0]     RD2_D;
    logic [XLEN-1:0]     WD_fwd;
    logic                fwd_valid;
    logic [XLEN-1:0]     retire_cnt;
    logic                trace_valid;
    logic                trace_ready;
    logic [XLEN-1:0]     trace_pc;
    logic [REG_AW-1:0]   trace_reg;
    logic [XLEN-1:0]     trace_data;
    logic [15:0]         trace_drop_cnt;

    modport master (
        output RegWriteW, MemtoRegW, jal_selW, ALUOutW, ReadDataW, WriteRegW,
               PcW, InstrW, T_new_W, A1_D, A2_D, trace_ready,
        input  RD1_D, RD2_D, WD_fwd, fwd_valid, retire_cnt, trace_valid,
               trace_pc, trace_reg, trace_data, trace_drop_cnt
    );

    modport slave (
        input  RegWriteW, MemtoRegW, jal_selW, ALUOutW, ReadDataW, WriteRegW,
               PcW, InstrW, T_new_W, A1_D, A2_D, trace_ready,
        output RD1_D, RD2_D, WD_fwd, fwd_valid, retire_cnt, trace_valid,
               trace_pc, trace_reg, trace_data, trace_drop_cnt
    );

endinterface

// File: rtl/wb_trace_fifo.sv
// Commit-record FIFO with valid/ready drain and saturating drop counter.
// Ports: clk, reset (async active-low), push/pushData (enqueue request),
//        popReady (consumer ready), valid/headData (head, zero when empty),
//        dropCnt (records discarded because the FIFO was full).
module wb_trace_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 69
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popReady,
    output logic             valid,
    output logic [WIDTH-1:0] headData,
    output logic [15:0]      dropCnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             doPop;
    logic             doPush;
    logic             doDrop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign doPop  = !empty && popReady;
    // A pop on the same edge frees the slot a full FIFO needs for the push
    assign doPush = push && (!full || doPop);
    assign doDrop = push && full && !doPop;

    // Pointers, occupancy and drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            dropCnt <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
            if (doDrop && dropCnt != 16'hFFFF) dropCnt <= dropCnt + 16'd1;
        end
    end

    // Record storage; contents are only observed through valid entries
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    assign valid    = !empty;
    assign headData = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/wb_grf_commit.sv
// W-stage consumer: writeback mux, 32x32 GPR file with W->D bypass,
// forwarding output, retired-instruction counter and commit trace FIFO.
// Ports: clk, reset (async active-low), bus (wb_grf_commit_if.slave) carrying
//        the W-stage bundle, D-stage read ports, forwarding and trace drain.
module wb_grf_commit
    import wb_grf_commit_pkg::*;
#(
    parameter int unsigned TRACE_DEPTH     = 4,
    parameter int unsigned JAL_LINK_OFFSET = 8
) (
    input  logic           clk,
    input  logic           reset,
    wb_grf_commit_if.slave bus
);

    logic [XLEN-1:0] grf [NUM_REGS];
    logic [XLEN-1:0] wbData;
    logic            weEff;
    logic [XLEN-1:0] retireCnt;
    traceRec_t       pushRec;
    traceRec_t       headRec;
    logic            headValid;
    logic [15:0]     dropCnt;

    assign wbData = selWbData(bus.jal_selW, bus.MemtoRegW, bus.PcW, bus.ALUOutW,
                              bus.ReadDataW, XLEN'(JAL_LINK_OFFSET));
    assign weEff  = bus.RegWriteW && (bus.WriteRegW != REG_ZERO);

    // GPR array; entry 0 is never written so it stays at its reset value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) grf[i] <= '0;
        end else if (weEff) begin
            grf[bus.WriteRegW] <= wbData;
        end
    end

    // Reads see the same-cycle writeback (write-before-read)
    assign bus.RD1_D = (bus.A1_D == REG_ZERO) ? '0 :
                       (weEff && bus.A1_D == bus.WriteRegW) ? wbData : grf[bus.A1_D];
    assign bus.RD2_D = (bus.A2_D == REG_ZERO) ? '0 :
                       (weEff && bus.A2_D == bus.WriteRegW) ? wbData : grf[bus.A2_D];

    assign bus.WD_fwd    = wbData;
    assign bus.fwd_valid = weEff && (bus.T_new_W == T_NEW_NOW);

    // Retired instruction counter; bubbles carry a zero instruction word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retireCnt <= '0;
        end else if (bus.InstrW != '0) begin
            retireCnt <= retireCnt + 32'd1;
        end
    end

    assign bus.retire_cnt = retireCnt;

    assign pushRec.pc   = bus.PcW;
    assign pushRec.rd   = bus.WriteRegW;
    assign pushRec.data = wbData;

    wb_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TRACE_W)
    ) u_trace_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (weEff),
        .pushData (pushRec),
        .popReady (bus.trace_ready),
        .valid    (headValid),
        .headData (headRec),
        .dropCnt  (dropCnt)
    );

    assign bus.trace_valid    = headValid;
    assign bus.trace_pc       = headRec.pc;
    assign bus.trace_reg      = headRec.rd;
    assign bus.trace_data     = headRec.data;
    assign bus.trace_drop_cnt = dropCnt;

endmodule

// File: tb/tb_wb_grf_commit.sv
// Self-checking bench for wb_grf_commit: directed scenarios followed by
// randomized traffic, checked against a queue/array reference model.
module tb_wb_grf_commit;
    import wb_grf_commit_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic reset;
    int   checks;
    int   passCnt;

    wb_grf_commit_if bus ();

    wb_grf_commit #(
        .TRACE_DEPTH     (DEPTH),
        .JAL_LINK_OFFSET (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mRegs [32];
    traceRec_t   mQ [$];
    logic [15:0] mDrop;
    logic [31:0] mRetire;

    function automatic logic [31:0] mWb();
        if (bus.jal_selW)  return bus.PcW + 32'd8;
        if (bus.MemtoRegW) return bus.ReadDataW;
        return bus.ALUOutW;
    endfunction

    function automatic logic mWe();
        return bus.RegWriteW && (bus.WriteRegW != 5'd0);
    endfunction

    function automatic logic [31:0] mRead(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (mWe() && a == bus.WriteRegW) return mWb();
        return mRegs[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
        mQ.delete();
        mDrop   = 16'd0;
        mRetire = 32'd0;
    endtask

    // Applies the effect of one rising edge to the model
    task automatic modelEdge();
        traceRec_t rec;
        logic      we;
        logic [31:0] wb;
        we = mWe();
        wb = mWb();
        if (bus.InstrW != 32'd0) mRetire = mRetire + 32'd1;
        if (mQ.size() != 0 && bus.trace_ready) void'(mQ.pop_front());
        if (we) begin
            rec.pc   = bus.PcW;
            rec.rd   = bus.WriteRegW;
            rec.data = wb;
            if (mQ.size() < DEPTH) mQ.push_back(rec);
            else if (mDrop != 16'hFFFF) mDrop = mDrop + 16'd1;
            mRegs[bus.WriteRegW] = wb;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkOutputs(input string tag);
        logic        ev;
        traceRec_t   h;
        ev = (mQ.size() != 0);
        h  = ev ? mQ[0] : '0;
        chk({tag, ".rd1"},   bus.RD1_D, mRead(bus.A1_D));
        chk({tag, ".rd2"},   bus.RD2_D, mRead(bus.A2_D));
        chk({tag, ".wdfwd"}, bus.WD_fwd, mWb());
        chk({tag, ".fwdv"},  32'(bus.fwd_valid), 32'(mWe() && bus.T_new_W == 2'b00));
        chk({tag, ".retire"}, bus.retire_cnt, mRetire);
        chk({tag, ".tvalid"}, 32'(bus.trace_valid), 32'(ev));
        chk({tag, ".tpc"},   bus.trace_pc, h.pc);
        chk({tag, ".treg"},  32'(bus.trace_reg), 32'(h.rd));
        chk({tag, ".tdata"}, bus.trace_data, h.data);
        chk({tag, ".drop"},  32'(bus.trace_drop_cnt), 32'(mDrop));
    endtask

    // Entered at posedge+1 with inputs already applied; leaves at next posedge+1
    task automatic tick(input string tag);
        #3;
        checkOutputs(tag);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic setW(input logic rw, input logic m2r, input logic jal,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [4:0] wr, input logic [31:0] pc,
                        input logic [31:0] instr, input logic [1:0] tnew);
        bus.RegWriteW = rw;
        bus.MemtoRegW = m2r;
        bus.jal_selW  = jal;
        bus.ALUOutW   = alu;
        bus.ReadDataW = rdata;
        bus.WriteRegW = wr;
        bus.PcW       = pc;
        bus.InstrW    = instr;
        bus.T_new_W   = tnew;
    endtask

    task automatic idle();
        setW(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 2'b00);
    endtask

    initial begin
        logic [15:0] dropSnap;
        logic [31:0] retSnap;
        int          guard;
        checks  = 0;
        passCnt = 0;
        reset   = 1'b0;
        idle();
        bus.A1_D        = 5'd0;
        bus.A2_D        = 5'd0;
        bus.trace_ready = 1'b0;
        modelReset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutputs("por");
        reset = 1'b1;

        // Writes to $5 and $6, then asynchronous reset mid-cycle
        setW(1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'd0, 5'd5, 32'h100, 32'h1, 2'b00);
        tick("w5");
        setW(1'b1, 1'b1, 1'b0, 32'd0, 32'h0000_0066, 5'd6, 32'h104, 32'h2, 2'b01);
        tick("w6");
        idle();
        bus.A1_D = 5'd5;
        bus.A2_D = 5'd6;
        #1;
        chk("pre_rst.rd1", bus.RD1_D, 32'h55);
        chk("pre_rst.rd2", bus.RD2_D, 32'h66);
        reset = 1'b0;
        #1;
        modelReset();
        chk("rst.rd1", bus.RD1_D, 32'd0);
        chk("rst.rd2", bus.RD2_D, 32'd0);
        chk("rst.retire", bus.retire_cnt, 32'd0);
        chk("rst.tvalid", 32'(bus.trace_valid), 32'd0);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Write to $0 is suppressed and pushes nothing
        setW(1'b1, 1'b0, 1'b0, 32'h1234, 32'd0, 5'd0, 32'h200, 32'h3, 2'b00);
        bus.A1_D = 5'd0;
        tick("w0");
        idle();
        #1;
        chk("w0.rd1", bus.RD1_D, 32'd0);
        chk("w0.tvalid", 32'(bus.trace_valid), 32'd0);
        @(posedge clk); #1;

        // Load writeback with same-cycle bypass
        setW(1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd8, 32'h204, 32'h4, 2'b00);
        bus.A1_D = 5'd8;
        #1;
        chk("ld.bypass", bus.RD1_D, 32'hDEAD_BEEF);
        chk("ld.fwdv", 32'(bus.fwd_valid), 32'd1);
        tick("ld");
        idle();
        #1;
        chk("ld.after", bus.RD1_D, 32'hDEAD_BEEF);
        bus.trace_ready = 1'b1;
        guard = 0;
        while (mQ.size() != 0 && guard < 8) begin
            tick("drain0");
            guard++;
        end
        chk("drain0.done", 32'(mQ.size()), 32'd0);

        // jal link write and its trace record
        bus.trace_ready = 1'b0;
        setW(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, REG_RA, 32'h0000_3000, 32'h5, 2'b00);
        bus.A1_D = 5'd31;
        tick("jal");
        idle();
        #1;
        chk("jal.rd1", bus.RD1_D, 32'h0000_3008);
        chk("jal.tpc", bus.trace_pc, 32'h0000_3000);
        chk("jal.treg", 32'(bus.trace_reg), 32'd31);
        chk("jal.tdata", bus.trace_data, 32'h0000_3008);
        bus.trace_ready = 1'b1;
        tick("jal_pop");
        bus.trace_ready = 1'b0;

        // Six writes into a four-entry FIFO with no drain
        for (int i = 0; i < 6; i++) begin
            setW(1'b1, 1'b0, 1'b0, 32'hA0 + 32'(i), 32'h0, 5'(10 + i),
                 32'h400 + 32'(4 * i), 32'h10 + 32'(i), 2'b10);
            tick("fill");
        end
        idle();
        #1;
        chk("fill.drop", 32'(bus.trace_drop_cnt), 32'd2);
        chk("fill.head", bus.trace_data, 32'hA0);
        bus.trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick("drain1");
        chk("drain1.tvalid", 32'(bus.trace_valid), 32'd0);

        // Full FIFO: simultaneous push and pop keeps the count and drop count
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setW(1'b1, 1'b0, 1'b0, 32'hB0 + 32'(i), 32'h0, 5'(20 + i),
                 32'h500 + 32'(4 * i), 32'h20 + 32'(i), 2'b00);
            tick("fill2");
        end
        dropSnap = bus.trace_drop_cnt;
        bus.trace_ready = 1'b1;
        setW(1'b1, 1'b0, 1'b0, 32'hC0, 32'h0, 5'd24, 32'h600, 32'h30, 2'b00);
        tick("pushpop");
        idle();
        bus.trace_ready = 1'b0;
        #1;
        chk("pushpop.drop", 32'(bus.trace_drop_cnt), 32'(dropSnap));
        chk("pushpop.head", bus.trace_data, 32'hB1);

        // Bubbles do not retire
        retSnap = bus.retire_cnt;
        for (int i = 0; i < 3; i++) tick("bubble");
        chk("bubble.retire", bus.retire_cnt, retSnap);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            setW(($urandom % 4) != 0, $urandom % 2, ($urandom % 8) == 0,
                 $urandom, $urandom, 5'($urandom % 32), $urandom,
                 (($urandom % 4) == 0) ? 32'd0 : $urandom, 2'($urandom % 4));
            bus.A1_D        = (($urandom % 3) == 0) ? bus.WriteRegW : 5'($urandom % 32);
            bus.A2_D        = 5'($urandom % 32);
            bus.trace_ready = ($urandom % 10) < 3;
            tick("rand");
        end

        $display("%0d/%0d checks passed", passCnt, checks);
        $finish;
    end

endmodule
